// File: rtl/array_ctrl_pkg.sv
// Shared constants and enums for the SRAM read/write scheduler.
package array_ctrl_pkg;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1024;
    localparam int LANES  = 10;
    localparam int LANE_W = 32;
    localparam int DATA_W = LANES * LANE_W;

    // Last address written by the clear sweep; the counter is one bit wider than the address.
    localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef enum logic {
        GNT_RD = 1'b0,
        GNT_WR = 1'b1
    } grant_e;

endpackage

// File: rtl/array_rd_resp_hold.sv
// Read-response path: tracks the read in flight, bypasses macro data on the cycle after a
// read grant and parks it in a one-entry hold register when the consumer stalls.
module array_rd_resp_hold
    import array_ctrl_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              i_rd_grant,
    input  logic              i_resp_ready,
    input  logic [DATA_W-1:0] i_sram_rdata,
    output logic              o_rd_allow,
    output logic              o_resp_valid,
    output logic [DATA_W-1:0] o_resp_data
);

    logic              r_inflight;
    logic              r_hold_valid;
    logic [DATA_W-1:0] r_hold_data;

    // A new read may issue only if its response slot is guaranteed free next cycle.
    assign o_rd_allow   = !r_hold_valid && (!r_inflight || i_resp_ready);
    assign o_resp_valid = r_inflight || r_hold_valid;
    assign o_resp_data  = r_hold_valid ? r_hold_data : i_sram_rdata;

    // Inflight and hold-valid flags; a reset drops any pending response.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_inflight   <= 1'b0;
            r_hold_valid <= 1'b0;
        end else begin
            r_inflight <= i_rd_grant;
            if (r_inflight && !i_resp_ready) begin
                r_hold_valid <= 1'b1;
            end else if (r_hold_valid && i_resp_ready) begin
                r_hold_valid <= 1'b0;
            end
        end
    end

    // Capture macro data at the end of the bypass cycle, before any same-cycle write lands.
    always_ff @(posedge clock) begin
        if (r_inflight && !i_resp_ready) begin
            r_hold_data <= i_sram_rdata;
        end
    end

endmodule

// File: rtl/array_rw_sched.sv
// Single-port SRAM scheduler: zero-clear sweep after reset or clear_req, then round-robin
// arbitration between read and write requesters onto the macro RW port.
//
// state   | meaning
// ST_INIT | clear sweep writing zeros to every address, clients blocked
// ST_RUN  | normal operation, read/write arbitration
module array_rw_sched
    import array_ctrl_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              clear_req,
    output logic              init_busy,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [ADDR_W-1:0] rd_req_addr,
    input  logic              wr_req_valid,
    output logic              wr_req_ready,
    input  logic [ADDR_W-1:0] wr_req_addr,
    input  logic [LANES-1:0]  wr_req_mask,
    input  logic [DATA_W-1:0] wr_req_data,
    output logic              rd_resp_valid,
    input  logic              rd_resp_ready,
    output logic [DATA_W-1:0] rd_resp_data,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [LANES-1:0]  sram_wmask,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    state_e          r_state;
    state_e          w_state_nxt;
    logic [ADDR_W:0] r_clear_cnt;
    logic [ADDR_W:0] w_clear_cnt_nxt;
    grant_e          r_last_grant;
    grant_e          w_last_grant_nxt;
    logic            w_rd_allow;
    logic            w_rd_elig;
    logic            w_wr_elig;
    logic            w_grant_rd;
    logic            w_grant_wr;

    // Outputs read as reset values while reset is held, not just after the edge.
    assign init_busy = reset || (r_state == ST_INIT);

    // State register, sweep counter and round-robin pointer.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_INIT;
            r_clear_cnt  <= '0;
            r_last_grant <= GNT_WR;
        end else begin
            r_state      <= w_state_nxt;
            r_clear_cnt  <= w_clear_cnt_nxt;
            r_last_grant <= w_last_grant_nxt;
        end
    end

    // Next state, arbitration and macro drive.
    always_comb begin
        w_state_nxt      = r_state;
        w_clear_cnt_nxt  = r_clear_cnt;
        w_last_grant_nxt = r_last_grant;
        w_rd_elig        = 1'b0;
        w_wr_elig        = 1'b0;
        w_grant_rd       = 1'b0;
        w_grant_wr       = 1'b0;
        sram_en          = 1'b0;
        sram_wmode       = 1'b0;
        sram_addr        = '0;
        sram_wmask       = '0;
        sram_wdata       = '0;

        case (r_state)
            ST_INIT: begin
                sram_en         = !reset;
                sram_wmode      = 1'b1;
                sram_addr       = r_clear_cnt[ADDR_W-1:0];
                sram_wmask      = '1;
                w_clear_cnt_nxt = r_clear_cnt + 1'b1;
                if (r_clear_cnt == CLR_LAST) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_rd_elig  = !reset && rd_req_valid && w_rd_allow;
                w_wr_elig  = !reset && wr_req_valid;
                w_grant_rd = w_rd_elig && (!w_wr_elig || (r_last_grant == GNT_WR));
                w_grant_wr = w_wr_elig && !w_grant_rd;
                if (w_grant_rd) begin
                    sram_en          = 1'b1;
                    sram_addr        = rd_req_addr;
                    w_last_grant_nxt = GNT_RD;
                end else if (w_grant_wr) begin
                    sram_en          = 1'b1;
                    sram_wmode       = 1'b1;
                    sram_addr        = wr_req_addr;
                    sram_wmask       = wr_req_mask;
                    sram_wdata       = wr_req_data;
                    w_last_grant_nxt = GNT_WR;
                end
                if (clear_req) begin
                    w_state_nxt     = ST_INIT;
                    w_clear_cnt_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    assign rd_req_ready = w_grant_rd;
    assign wr_req_ready = w_grant_wr;

    array_rd_resp_hold u_resp_hold (
        .clock        (clock),
        .reset        (reset),
        .i_rd_grant   (w_grant_rd),
        .i_resp_ready (rd_resp_ready),
        .i_sram_rdata (sram_rdata),
        .o_rd_allow   (w_rd_allow),
        .o_resp_valid (rd_resp_valid),
        .o_resp_data  (rd_resp_data)
    );

endmodule
